router_reg: RTL and testbench

//  Datapath register stage of the 1x3 router, between the input port and the three output FIFOs.

---
 rtl/router_reg_if.sv | 51 +++++
 rtl/router_reg.sv | 112 +++++++++++
 tb/tb_router_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/router_reg_if.sv
// Byte-stream bundle between the router FSM/input port and the register stage.
// The slave side is the register stage; the master side drives strobes and data.
interface router_reg_if #(
  parameter int DATA_W = 8
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              lfd_state;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic [DATA_W-1:0] dout;

  modport slave (
    input  pkt_valid,
    input  data_in,
    input  fifo_full,
    input  rst_int_reg,
    input  detect_add,
    input  ld_state,
    input  laf_state,
    input  full_state,
    input  lfd_state,
    output parity_done,
    output low_pkt_valid,
    output err,
    output dout
  );

  modport master (
    output pkt_valid,
    output data_in,
    output fifo_full,
    output rst_int_reg,
    output detect_add,
    output ld_state,
    output laf_state,
    output full_state,
    output lfd_state,
    input  parity_done,
    input  low_pkt_valid,
    input  err,
    input  dout
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header/payload buffering, full-hold byte,
// running XOR parity and parity-byte check for the 1x3 router.
module router_reg #(
  parameter int DATA_W = 8
) (
  input  logic         clock,
  input  logic         reset,
  router_reg_if.slave  bus
);
  localparam logic [1:0] BAD_ADDR = 2'b11;

  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] ffb;
  logic [DATA_W-1:0] int_par;
  logic [DATA_W-1:0] pkt_par;
  logic [DATA_W-1:0] dout_q;
  logic              done_q;
  logic              done_d1;
  logic              low_q;
  logic              err_q;

  logic ld_byte;
  logic addr_ok;

  assign ld_byte = bus.ld_state & bus.pkt_valid;
  assign addr_ok = bus.data_in[1:0] != BAD_ADDR;

  assign bus.dout          = dout_q;
  assign bus.parity_done   = done_q;
  assign bus.low_pkt_valid = low_q;
  assign bus.err           = err_q;

  // Capture the header byte only when it addresses a real output port.
  always_ff @(posedge clock) begin
    if (reset)
      hdr <= '0;
    else if (bus.detect_add && bus.pkt_valid && addr_ok)
      hdr <= bus.data_in;
  end

  // Output byte select; a byte arriving while the FIFO is full is parked in ffb.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout_q <= '0;
      ffb    <= '0;
    end else if (bus.detect_add) begin
      dout_q <= dout_q;
    end else if (bus.lfd_state) begin
      dout_q <= hdr;
    end else if (ld_byte && !bus.fifo_full) begin
      dout_q <= bus.data_in;
    end else if (ld_byte && bus.fifo_full) begin
      ffb    <= bus.data_in;
    end else if (bus.laf_state) begin
      dout_q <= ffb;
    end
  end

  // Running parity; the parked byte was counted on arrival, so laf adds nothing.
  always_ff @(posedge clock) begin
    if (reset)
      int_par <= '0;
    else if (bus.detect_add)
      int_par <= '0;
    else if (bus.lfd_state)
      int_par <= int_par ^ hdr;
    else if (ld_byte && !bus.full_state)
      int_par <= int_par ^ bus.data_in;
  end

  // Latch the trailing parity byte once per packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_par <= '0;
      done_q  <= 1'b0;
    end else if (bus.detect_add) begin
      pkt_par <= '0;
      done_q  <= 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid && !done_q) begin
      pkt_par <= bus.data_in;
      done_q  <= 1'b1;
    end
  end

  // Delayed parity_done for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset)
      done_d1 <= 1'b0;
    else
      done_d1 <= done_q;
  end

  // pkt_valid dropped during LOAD_DATA; FSM clear wins over a new set.
  always_ff @(posedge clock) begin
    if (reset)
      low_q <= 1'b0;
    else if (bus.rst_int_reg)
      low_q <= 1'b0;
    else if (bus.ld_state && !bus.pkt_valid)
      low_q <= 1'b1;
  end

  // Compare parities one cycle after the parity byte lands.
  always_ff @(posedge clock) begin
    if (reset)
      err_q <= 1'b0;
    else if (bus.detect_add)
      err_q <= 1'b0;
    else if (done_q && !done_d1)
      err_q <= int_par != pkt_par;
  end
endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: dout scoreboard queue plus flag checks.
// Strobe vector order is {rst_int_reg, detect_add, ld, laf, full, lfd}.
module tb_router_reg;
  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] RI   = 6'b100000;
  localparam logic [5:0] DA   = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LAF  = 6'b000100;
  localparam logic [5:0] FS   = 6'b000010;
  localparam logic [5:0] LFD  = 6'b000001;

  logic clock;
  logic reset;
  int   nchk;
  int   nerr;
  logic [7:0] q[$];

  router_reg_if #(.DATA_W(8)) bus ();

  router_reg #(.DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic pv,
                      input logic ff, input logic [5:0] st);
    bus.data_in     = d;
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    bus.rst_int_reg = st[5];
    bus.detect_add  = st[4];
    bus.ld_state    = st[3];
    bus.laf_state   = st[2];
    bus.full_state  = st[1];
    bus.lfd_state   = st[0];
    @(posedge clock);
    #1;
  endtask

  task automatic dstep(input string tag, input logic [7:0] d,
                       input logic pv, input logic ff,
                       input logic [5:0] st, input logic [7:0] exp);
    logic [7:0] e;
    q.push_back(exp);
    step(d, pv, ff, st);
    if (q.size() == 0) begin
      nchk++;
      nerr++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk(tag, bus.dout, e);
    end
  endtask

  initial begin
    nchk  = 0;
    nerr  = 0;
    reset = 1'b1;
    step(8'h00, 1'b0, 1'b0, IDLE);
    step(8'h00, 1'b0, 1'b0, IDLE);
    chk("t1_dout", bus.dout, 8'h00);
    chk("t1_pdone", {7'd0, bus.parity_done}, 8'h00);
    chk("t1_low", {7'd0, bus.low_pkt_valid}, 8'h00);
    chk("t1_err", {7'd0, bus.err}, 8'h00);
    reset = 1'b0;

    // T2 good packet
    dstep("t2_da", 8'h0D, 1'b1, 1'b0, DA, 8'h00);
    dstep("t2_hdr", 8'h11, 1'b1, 1'b0, LFD, 8'h0D);
    dstep("t2_d0", 8'h11, 1'b1, 1'b0, LD, 8'h11);
    dstep("t2_d1", 8'h22, 1'b1, 1'b0, LD, 8'h22);
    dstep("t2_d2", 8'h33, 1'b1, 1'b0, LD, 8'h33);
    dstep("t2_par", 8'h0D, 1'b0, 1'b0, LD, 8'h33);
    chk("t2_pdone", {7'd0, bus.parity_done}, 8'h01);
    chk("t2_low", {7'd0, bus.low_pkt_valid}, 8'h01);
    step(8'h00, 1'b0, 1'b0, IDLE);
    chk("t2_err", {7'd0, bus.err}, 8'h00);
    step(8'h00, 1'b0, 1'b0, RI);
    chk("t2_lowclr", {7'd0, bus.low_pkt_valid}, 8'h00);

    // T3 bad parity
    dstep("t3_da", 8'h0D, 1'b1, 1'b0, DA, 8'h33);
    chk("t3_pd0", {7'd0, bus.parity_done}, 8'h00);
    dstep("t3_hdr", 8'h11, 1'b1, 1'b0, LFD, 8'h0D);
    dstep("t3_d0", 8'h11, 1'b1, 1'b0, LD, 8'h11);
    dstep("t3_d1", 8'h22, 1'b1, 1'b0, LD, 8'h22);
    dstep("t3_d2", 8'h33, 1'b1, 1'b0, LD, 8'h33);
    step(8'h0E, 1'b0, 1'b0, LD);
    chk("t3_pdone", {7'd0, bus.parity_done}, 8'h01);
    chk("t3_err_early", {7'd0, bus.err}, 8'h00);
    step(8'h00, 1'b0, 1'b0, IDLE);
    chk("t3_err", {7'd0, bus.err}, 8'h01);
    step(8'h00, 1'b0, 1'b0, IDLE);
    chk("t3_err_hold", {7'd0, bus.err}, 8'h01);
    step(8'h00, 1'b0, 1'b0, RI);
    step(8'h0D, 1'b1, 1'b0, DA);
    chk("t3_err_clr", {7'd0, bus.err}, 8'h00);

    // T4 FIFO full mid-packet
    dstep("t4_hdr", 8'h11, 1'b1, 1'b0, LFD, 8'h0D);
    dstep("t4_d0", 8'h11, 1'b1, 1'b0, LD, 8'h11);
    dstep("t4_full", 8'h22, 1'b1, 1'b1, LD, 8'h11);
    dstep("t4_fs", 8'h33, 1'b1, 1'b1, FS, 8'h11);
    dstep("t4_laf", 8'h33, 1'b1, 1'b0, LAF, 8'h22);
    dstep("t4_d2", 8'h33, 1'b1, 1'b0, LD, 8'h33);
    step(8'h0D, 1'b0, 1'b0, LD);
    chk("t4_pdone", {7'd0, bus.parity_done}, 8'h01);
    step(8'h00, 1'b0, 1'b0, IDLE);
    chk("t4_err", {7'd0, bus.err}, 8'h00);

    // T5 invalid address and rst_int_reg priority
    step(8'h0F, 1'b1, 1'b0, DA);
    dstep("t5_hdr_kept", 8'h00, 1'b1, 1'b0, LFD, 8'h0D);
    step(8'h00, 1'b0, 1'b0, RI | LD);
    chk("t5_low_ri", {7'd0, bus.low_pkt_valid}, 8'h00);
    step(8'h00, 1'b0, 1'b0, LD);
    chk("t5_low_set", {7'd0, bus.low_pkt_valid}, 8'h01);
    step(8'h00, 1'b0, 1'b0, RI);

    // T6 reset mid-payload then a fresh packet
    step(8'h0D, 1'b1, 1'b0, DA);
    step(8'h11, 1'b1, 1'b0, LFD);
    step(8'h11, 1'b1, 1'b0, LD);
    reset = 1'b1;
    step(8'h22, 1'b0, 1'b0, LD);
    chk("t6_dout", bus.dout, 8'h00);
    chk("t6_pdone", {7'd0, bus.parity_done}, 8'h00);
    chk("t6_low", {7'd0, bus.low_pkt_valid}, 8'h00);
    chk("t6_err", {7'd0, bus.err}, 8'h00);
    reset = 1'b0;
    dstep("t6_da", 8'h05, 1'b1, 1'b0, DA, 8'h00);
    dstep("t6_hdr", 8'hAA, 1'b1, 1'b0, LFD, 8'h05);
    dstep("t6_d0", 8'hAA, 1'b1, 1'b0, LD, 8'hAA);
    step(8'hAF, 1'b0, 1'b0, LD);
    chk("t6_pd", {7'd0, bus.parity_done}, 8'h01);
    step(8'h00, 1'b0, 1'b0, IDLE);
    chk("t6_err2", {7'd0, bus.err}, 8'h00);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
